// File: rtl/icache_dm_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Covers FSM state encoding, bus request type and line geometry.
package icache_dm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_REFILL,
    ST_RESP
  } state_e;

  localparam logic [2:0] RD_TYPE_LINE = 3'b100;
  localparam int WORD_W = 32;
  localparam int WORDS  = 4;
  localparam int LINE_W = WORD_W * WORDS;
  localparam int ADDR_W = 32;

  function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                               input logic [1:0] sel);
    return line[sel*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side request/response and refill-bridge signals of the icache.
// slave = cache side, master = fetch stage plus bus bridge.
interface icache_dm_if #(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
);

  logic                valid;
  logic                op;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] offset;
  logic                addr_ok;
  logic                data_ok;
  logic [31:0]         rdata;

  logic                rd_req;
  logic [2:0]          rd_type;
  logic [31:0]         rd_addr;
  logic                rd_rdy;
  logic                ret_valid;
  logic                ret_last;
  logic [31:0]         ret_data;

  modport slave (
    input  valid, op, index, tag, offset, rd_rdy, ret_valid, ret_last, ret_data,
    output addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr
  );

  modport master (
    output valid, op, index, tag, offset, rd_rdy, ret_valid, ret_last, ret_data,
    input  addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr
  );

endinterface

// File: rtl/icache_line_ram.sv
// Tag plus 4-word line storage: one write port, one registered read port.
// Contents are never reset; the valid bits in the cache decide hits.
module icache_line_ram
  import icache_dm_pkg::*;
#(
  parameter int TAG_W   = 20,
  parameter int INDEX_W = 8
) (
  input  logic               clk,
  input  logic               rd_en_i,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]  rd_line_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [LINE_W-1:0]  wr_line_i
);

  localparam int SETS = 1 << INDEX_W;

  logic [TAG_W+LINE_W-1:0] mem_q [SETS];
  logic [TAG_W+LINE_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_index_i] <= {wr_tag_i, wr_line_i};
    end
    if (rd_en_i) begin
      rd_q <= mem_q[rd_index_i];
    end
  end

  assign {rd_tag_o, rd_line_o} = rd_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with a single outstanding miss.
// Misses fetch the whole line in ascending word order and replace the set.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic       clk,
  input  logic       resetn,
  icache_dm_if.slave bus
);

  localparam int SETS = 1 << INDEX_W;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   beat_q [WORDS];
  logic [WORD_W-1:0]   beat_d [WORDS];
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SETS-1:0]     valid_q, valid_d;

  logic                hit;
  logic                accept;
  logic                data_ok;
  logic [WORD_W-1:0]   rdata;
  logic                rd_req;

  logic [TAG_W-1:0]    ram_tag;
  logic [LINE_W-1:0]   ram_line;
  logic                ram_wr_en;
  logic [LINE_W-1:0]   ram_wr_line;

  logic                unused_bits;
  assign unused_bits = ^{bus.op, bus.offset};

  icache_line_ram #(
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W)
  ) u_line_ram (
    .clk        (clk),
    .rd_en_i    (accept),
    .rd_index_i (bus.index),
    .rd_tag_o   (ram_tag),
    .rd_line_o  (ram_line),
    .wr_en_i    (ram_wr_en),
    .wr_index_i (index_q),
    .wr_tag_i   (tag_q),
    .wr_line_i  (ram_wr_line)
  );

  // The final beat goes straight into the written line; earlier beats come from the buffer.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_wr_line
    assign ram_wr_line[gi*WORD_W +: WORD_W] =
      (bus.ret_valid && (cnt_q == 2'(gi))) ? bus.ret_data : beat_q[gi];
  end

  assign hit    = (state_q == ST_LOOKUP) && valid_q[index_q] && (ram_tag == tag_q);
  assign accept = resetn && bus.valid && ((state_q == ST_IDLE) || hit);

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    index_d   = index_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    word_d    = word_q;
    valid_d   = valid_q;
    ram_wr_en = 1'b0;
    data_ok   = 1'b0;
    rdata     = '0;
    rd_req    = 1'b0;

    if (accept) begin
      tag_d   = bus.tag;
      index_d = bus.index;
      sel_d   = bus.offset[3:2];
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          data_ok = 1'b1;
          rdata   = word_of(ram_line, sel_q);
          state_d = accept ? ST_LOOKUP : ST_IDLE;
        end else begin
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        rd_req = 1'b1;
        if (bus.rd_rdy) begin
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (bus.ret_valid) begin
          beat_d[cnt_q] = bus.ret_data;
          if (cnt_q == sel_q) begin
            word_d = bus.ret_data;
          end
          cnt_d = cnt_q + 2'd1;
          if (bus.ret_last) begin
            ram_wr_en        = 1'b1;
            valid_d[index_q] = 1'b1;
            cnt_d            = 2'd0;
            state_d          = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        data_ok = 1'b1;
        rdata   = word_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      index_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '{default: '0};
      word_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign bus.addr_ok = accept;
  assign bus.data_ok = data_ok;
  assign bus.rdata   = rdata;
  assign bus.rd_req  = rd_req;
  assign bus.rd_type = RD_TYPE_LINE;
  assign bus.rd_addr = 32'({tag_q, index_q, {OFFSET_W{1'b0}}});

endmodule
